multi_dac_loopback_receiver: RTL and testbench

//  I2S receiver for the 4-channel, 2-data-line stream driven to the PCM1794A DAC board.

---
 rtl/multi_dac_loopback_receiver_pkg.sv | 24 ++
 rtl/multi_dac_loopback_receiver_line_deserializer.sv | 28 ++
 rtl/multi_dac_loopback_receiver.sv | 167 ++++++++++++++++
 tb/tb_multi_dac_loopback_receiver.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_dac_loopback_receiver_pkg.sv
// Shared I2S framing constants, FSM state encoding and channel-to-line map for the loopback receiver.
// Latency: n/a (constants only).
// Backpressure: n/a.
package multi_dac_loopback_receiver_pkg;

    localparam int DAC_CHIPS    = 2;
    localparam int WORD_BITS    = 24;
    localparam int LRCK_DIVISOR = 512;
    // BCK is capture_clk/2, so one LRCK half holds LRCK_DIVISOR/4 BCK periods
    localparam int BCK_PER_HALF = LRCK_DIVISOR / 4;
    localparam int SYNC_STAGES  = 2;
    localparam int NUM_CH       = 4;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

    // Channel order is 0R 0L 1R 1L: bit ch gives the data line / side of channel ch
    localparam logic [NUM_CH-1:0] CH_LINE     = 4'b1100;
    localparam logic [NUM_CH-1:0] CH_IS_RIGHT = 4'b0101;

endpackage

// File: rtl/multi_dac_loopback_receiver_line_deserializer.sv
// One serial data line: MSB-first shifter, cleared at every word boundary.
// Latency: word visible one capture_clk after the last shift strobe.
// Backpressure: none; shifts whenever shift_en is high.
module i2s_line_deserializer
    import multi_dac_loopback_receiver_pkg::*;
#(
    parameter int word_bits = WORD_BITS
) (
    input  logic                 capture_clk,
    input  logic                 not_rst,
    input  logic                 clr,
    input  logic                 shift_en,
    input  logic                 bit_in,
    output logic [word_bits-1:0] word
);

    // Clear on word boundary so a short word never inherits stale bits, else shift MSB first
    always_ff @(posedge capture_clk) begin
        if (!not_rst) begin
            word <= '0;
        end else if (clr) begin
            word <= '0;
        end else if (shift_en) begin
            word <= {word[word_bits-2:0], bit_in};
        end
    end

endmodule

// File: rtl/multi_dac_loopback_receiver.sv
// I2S loopback receiver: 2 data lines -> four 32-bit samples {ch0,ch1,ch2,ch3} (0R 0L 1R 1L).
// Latency: sample_valid sync_stages+1 capture_clk after the BCK rise that samples LRCK low.
// Backpressure: none; one-cycle strobe, data held until next strobe. Option: DAC_LOOPBACK_FRAME_CHECK_EN.
module multi_dac_loopback_receiver
    import multi_dac_loopback_receiver_pkg::*;
#(
    parameter int dac_chips    = DAC_CHIPS,
    parameter int word_bits    = WORD_BITS,
    parameter int bck_per_half = BCK_PER_HALF,
    parameter int sync_stages  = SYNC_STAGES
) (
    input  logic         capture_clk,
    input  logic         not_rst,
    input  logic         I2S_BCK,
    input  logic         I2S_LRCK,
    input  logic [0:1]   I2S_DATA_PINS,
    output logic [127:0] sample_data,
    output logic         sample_valid,
    output logic         frame_error
);

    localparam int               PAD_BITS    = 32 - word_bits;
    // Counter wide enough for 2*bck_per_half; it saturates at all-ones
    localparam int               CNT_W       = $clog2(bck_per_half) + 1;
    localparam logic [CNT_W-1:0] WORD_BITS_C = CNT_W'(word_bits);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [sync_stages-1:0] bck_sync;
    logic [sync_stages-1:0] lrck_sync;
    logic                   bck_prev;
    logic                   lrck_prev;
    logic                   bck_rise;
    logic                   lrck_now;
    logic                   lr_edge;
    logic                   shift_en;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [dac_chips-1:0]   line_bit;
    logic [word_bits-1:0]   live_word [dac_chips];
    logic [word_bits-1:0]   hold_word [dac_chips];
    logic [127:0]           frame_next;
    rx_state_t              state;

    // Synchronise BCK and LRCK into capture_clk and remember last synced BCK for edge detect
    always_ff @(posedge capture_clk) begin
        if (!not_rst) begin
            bck_sync  <= '0;
            lrck_sync <= '0;
            bck_prev  <= 1'b0;
        end else begin
            bck_sync  <= {bck_sync[sync_stages-2:0], I2S_BCK};
            lrck_sync <= {lrck_sync[sync_stages-2:0], I2S_LRCK};
            bck_prev  <= bck_sync[sync_stages-1];
        end
    end

    assign bck_rise = bck_sync[sync_stages-1] & ~bck_prev;
    assign lrck_now = lrck_sync[sync_stages-1];
    assign lr_edge  = bck_rise & (lrck_now ^ lrck_prev);

    // Bit position within the current half: 0 is the dummy bit right after an LRCK edge
    always_comb begin
        cnt_next = bit_cnt;
        if (lr_edge) begin
            cnt_next = '0;
        end else if (bit_cnt != CNT_MAX) begin
            cnt_next = bit_cnt + 1'b1;
        end
    end

    // Only positions 1..word_bits are payload; everything later is pad
    assign shift_en = bck_rise & ~lr_edge & (cnt_next <= WORD_BITS_C);

    for (genvar g = 0; g < dac_chips; g++) begin : g_line
        logic [sync_stages-1:0] dsync;

        // Data lines share the BCK/LRCK synchroniser depth so they stay aligned
        always_ff @(posedge capture_clk) begin
            if (!not_rst) begin
                dsync <= '0;
            end else begin
                dsync <= {dsync[sync_stages-2:0], I2S_DATA_PINS[g]};
            end
        end

        assign line_bit[g] = dsync[sync_stages-1];

        i2s_line_deserializer #(
            .word_bits (word_bits)
        ) u_deser (
            .capture_clk (capture_clk),
            .not_rst     (not_rst),
            .clr         (lr_edge),
            .shift_en    (shift_en),
            .bit_in      (line_bit[g]),
            .word        (live_word[g])
        );
    end

    // Right words come straight from the shifters at the closing edge, left words from the holding regs
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_slot
        localparam int LINE = int'(CH_LINE[ch]);
        if (CH_IS_RIGHT[ch]) begin : g_right
            assign frame_next[127-32*ch -: 32] = {live_word[LINE], {PAD_BITS{1'b0}}};
        end else begin : g_left
            assign frame_next[127-32*ch -: 32] = {hold_word[LINE], {PAD_BITS{1'b0}}};
        end
    end

    // Framing FSM: hunt for a left-word start, latch left words, emit the frame on the next left start
    always_ff @(posedge capture_clk) begin
        if (!not_rst) begin
            state        <= HUNT;
            bit_cnt      <= '0;
            lrck_prev    <= 1'b0;
            hold_word[0] <= '0;
            hold_word[1] <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (bck_rise) begin
                lrck_prev <= lrck_now;
                bit_cnt   <= cnt_next;
                if (lr_edge) begin
                    case (state)
                        HUNT: begin
                            if (!lrck_now) state <= LEFT;
                        end
                        LEFT: begin
                            if (lrck_now) begin
                                hold_word[0] <= live_word[0];
                                hold_word[1] <= live_word[1];
                                state        <= RIGHT;
                            end
                        end
                        RIGHT: begin
                            if (!lrck_now) begin
                                sample_data  <= frame_next;
                                sample_valid <= 1'b1;
                                state        <= LEFT;
                            end
                        end
                        default: state <= HUNT;
                    endcase
                end
            end
        end
    end

`ifdef DAC_LOOPBACK_FRAME_CHECK_EN
    localparam logic [CNT_W-1:0] LAST_BIT_C = CNT_W'(bck_per_half - 1);

    // Sticky flag: the half just closed was short or had the wrong BCK count
    always_ff @(posedge capture_clk) begin
        if (!not_rst) begin
            frame_error <= 1'b0;
        end else if (lr_edge && (state != HUNT) &&
                     ((bit_cnt < WORD_BITS_C) || (bit_cnt != LAST_BIT_C))) begin
            frame_error <= 1'b1;
        end
    end
`else
    assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_multi_dac_loopback_receiver.sv
module tb_multi_dac_loopback_receiver;

`ifdef DAC_LOOPBACK_FRAME_CHECK_EN
    localparam logic FE_EXP = 1'b1;
`else
    localparam logic FE_EXP = 1'b0;
`endif

    localparam logic [127:0] EXP_A = 128'h12345600_89ABCD00_00000100_FFFFFF00;
    localparam logic [127:0] EXP_B = 128'hA5A5A500_5A5A5A00_C3C3C300_3C3C3C00;
    localparam logic [127:0] EXP_C = 128'h01020300_04050600_07080900_0A0B0C00;
    localparam logic [127:0] EXP_D = 128'hDEADBE00_00FACE00_0BADC000_FEED0000;
    localparam logic [127:0] EXP_E = 128'h80000000_7FFFFF00_80000000_7FFFFF00;
    localparam logic [127:0] EXP_F = 128'h7FFFFF00_80000000_7FFFFF00_80000000;

    logic         capture_clk = 1'b0;
    logic         not_rst = 1'b0;
    logic         i2s_bck = 1'b0;
    logic         i2s_lrck = 1'b1;
    logic [0:1]   data_pins = 2'b00;
    logic [127:0] sample_data;
    logic         sample_valid;
    logic         frame_error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int strobes = 0;
    int wide_cnt = 0;
    int last_strobe_cyc = 0;
    int prev_strobe_cyc = 0;
    int last_fall_cyc = 0;
    logic valid_prev = 1'b0;
    logic [127:0] last_data = '0;

    multi_dac_loopback_receiver dut (
        .capture_clk   (capture_clk),
        .not_rst       (not_rst),
        .I2S_BCK       (i2s_bck),
        .I2S_LRCK      (i2s_lrck),
        .I2S_DATA_PINS (data_pins),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .frame_error   (frame_error)
    );

    always #5 capture_clk = ~capture_clk;

    always @(posedge capture_clk) cyc <= cyc + 1;

    always @(negedge capture_clk) begin
        if (sample_valid === 1'b1) begin
            if (valid_prev) wide_cnt++;
            strobes++;
            prev_strobe_cyc = last_strobe_cyc;
            last_strobe_cyc = cyc;
            last_data = sample_data;
        end
        valid_prev = (sample_valid === 1'b1);
    end

    // One LRCK half: slot 0 is the dummy bit (driven 1), slots 1..nbits carry the words MSB first
    task automatic send_half(input logic lr, input logic [23:0] w0, input logic [23:0] w1,
                             input int nbck, input int nbits);
        for (int k = 0; k < nbck; k++) begin
            i2s_bck = 1'b0;
            i2s_lrck = lr;
            if (k == 0) begin
                data_pins = 2'b11;
            end else if (k <= nbits) begin
                data_pins[0] = w0[5'(24 - k)];
                data_pins[1] = w1[5'(24 - k)];
            end else begin
                data_pins = 2'b00;
            end
            @(posedge capture_clk); #1;
            i2s_bck = 1'b1;
            if (k == 0 && lr == 1'b0) last_fall_cyc = cyc;
            @(posedge capture_clk); #1;
        end
    endtask

    task automatic send_frame(input logic [31:0] c0, input logic [31:0] c1,
                              input logic [31:0] c2, input logic [31:0] c3);
        send_half(1'b0, c1[31:8], c3[31:8], 128, 24);
        send_half(1'b1, c0[31:8], c2[31:8], 128, 24);
    endtask

    task automatic do_reset();
        not_rst = 1'b0;
        repeat (2) @(posedge capture_clk);
        #1 not_rst = 1'b1;
    endtask

    task automatic preamble();
        send_half(1'b1, 24'h0, 24'h0, 4, 0);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge capture_clk);
        checks++;
        if (sample_data !== 128'h0) begin
            failures++; $display("FAIL reset_data: got %h expected 0", sample_data);
        end
        checks++;
        if (sample_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b expected 0", sample_valid);
        end
        checks++;
        if (frame_error !== 1'b0) begin
            failures++; $display("FAIL reset_frame_error: got %b expected 0", frame_error);
        end
        @(posedge capture_clk); #1;
    endtask

    task automatic test_loopback();
        int s0;
        do_reset();
        preamble();
        s0 = strobes;
        for (int i = 0; i < 3; i++) send_frame(32'h123456AB, 32'h89ABCDEF, 32'h00000100, 32'hFFFFFF00);
        checks++;
        if (strobes - s0 !== 2) begin
            failures++; $display("FAIL loopback_count: got %0d expected 2", strobes - s0);
        end
        checks++;
        if (last_data !== EXP_A) begin
            failures++; $display("FAIL loopback_data: got %h expected %h", last_data, EXP_A);
        end
        checks++;
        if (last_strobe_cyc - last_fall_cyc !== 3) begin
            failures++; $display("FAIL loopback_latency: got %0d expected 3", last_strobe_cyc - last_fall_cyc);
        end
        checks++;
        if (last_strobe_cyc - prev_strobe_cyc !== 512) begin
            failures++; $display("FAIL loopback_period: got %0d expected 512", last_strobe_cyc - prev_strobe_cyc);
        end
        checks++;
        if (frame_error !== 1'b0) begin
            failures++; $display("FAIL loopback_frame_error: got %b expected 0", frame_error);
        end
    endtask

    task automatic test_full_scale();
        do_reset();
        preamble();
        send_frame(32'h80000000, 32'h7FFFFF00, 32'h80000000, 32'h7FFFFF00);
        send_frame(32'h7FFFFF00, 32'h80000000, 32'h7FFFFF00, 32'h80000000);
        checks++;
        if (last_data !== EXP_E) begin
            failures++; $display("FAIL fullscale_e: got %h expected %h", last_data, EXP_E);
        end
        send_frame(32'h7FFFFF00, 32'h80000000, 32'h7FFFFF00, 32'h80000000);
        checks++;
        if (last_data !== EXP_F) begin
            failures++; $display("FAIL fullscale_f: got %h expected %h", last_data, EXP_F);
        end
    endtask

    task automatic test_reset_mid_right();
        int s0;
        do_reset();
        preamble();
        send_frame(32'h123456AB, 32'h89ABCDEF, 32'h00000100, 32'hFFFFFF00);
        send_frame(32'h123456AB, 32'h89ABCDEF, 32'h00000100, 32'hFFFFFF00);
        not_rst = 1'b0;
        s0 = strobes;
        send_half(1'b0, 24'h89ABCD, 24'hFFFFFF, 128, 24);
        send_half(1'b1, 24'h123456, 24'h000001, 40, 24);
        not_rst = 1'b1;
        send_half(1'b1, 24'h123456, 24'h000001, 88, 24);
        checks++;
        if (sample_data !== 128'h0) begin
            failures++; $display("FAIL midright_cleared: got %h expected 0", sample_data);
        end
        send_frame(32'hA5A5A500, 32'h5A5A5A00, 32'hC3C3C300, 32'h3C3C3C00);
        checks++;
        if (strobes - s0 !== 0) begin
            failures++; $display("FAIL midright_early: got %0d strobes expected 0", strobes - s0);
        end
        send_frame(32'hA5A5A500, 32'h5A5A5A00, 32'hC3C3C300, 32'h3C3C3C00);
        checks++;
        if (strobes - s0 !== 1) begin
            failures++; $display("FAIL midright_count: got %0d expected 1", strobes - s0);
        end
        checks++;
        if (last_data !== EXP_B) begin
            failures++; $display("FAIL midright_data: got %h expected %h", last_data, EXP_B);
        end
    endtask

    task automatic test_reset_pulse();
        int s0;
        do_reset();
        preamble();
        send_frame(32'h01020300, 32'h04050600, 32'h07080900, 32'h0A0B0C00);
        send_half(1'b0, 24'h0, 24'h0, 60, 24);
        checks++;
        if (last_data !== EXP_C) begin
            failures++; $display("FAIL pulse_pre_data: got %h expected %h", last_data, EXP_C);
        end
        not_rst = 1'b0;
        @(posedge capture_clk); #1;
        not_rst = 1'b1;
        @(negedge capture_clk);
        checks++;
        if (sample_data !== 128'h0 || sample_valid !== 1'b0 || frame_error !== 1'b0) begin
            failures++; $display("FAIL pulse_outputs: got %h/%b/%b expected 0/0/0", sample_data, sample_valid, frame_error);
        end
        s0 = strobes;
        @(posedge capture_clk); #1;
        send_half(1'b0, 24'h0, 24'h0, 68, 0);
        send_half(1'b1, 24'h0, 24'h0, 128, 0);
        send_frame(32'hDEADBE00, 32'h00FACE00, 32'h0BADC000, 32'hFEED0000);
        checks++;
        if (strobes - s0 !== 0) begin
            failures++; $display("FAIL pulse_early: got %0d strobes expected 0", strobes - s0);
        end
        send_frame(32'hDEADBE00, 32'h00FACE00, 32'h0BADC000, 32'hFEED0000);
        checks++;
        if (strobes - s0 !== 1) begin
            failures++; $display("FAIL pulse_count: got %0d expected 1", strobes - s0);
        end
        checks++;
        if (last_data !== EXP_D) begin
            failures++; $display("FAIL pulse_data: got %h expected %h", last_data, EXP_D);
        end
    endtask

    task automatic test_lrck_stall();
        int s0;
        do_reset();
        preamble();
        send_frame(32'h123456AB, 32'h89ABCDEF, 32'h00000100, 32'hFFFFFF00);
        send_frame(32'hA5A5A500, 32'h5A5A5A00, 32'hC3C3C300, 32'h3C3C3C00);
        s0 = strobes;
        send_half(1'b1, 24'hFFFFFF, 24'hFFFFFF, 1000, 0);
        checks++;
        if (strobes - s0 !== 0) begin
            failures++; $display("FAIL stall_count: got %0d expected 0", strobes - s0);
        end
        checks++;
        if (sample_data !== EXP_A) begin
            failures++; $display("FAIL stall_data: got %h expected %h", sample_data, EXP_A);
        end
        send_frame(32'h01020300, 32'h04050600, 32'h07080900, 32'h0A0B0C00);
        checks++;
        if (strobes - s0 !== 1) begin
            failures++; $display("FAIL stall_resume_count: got %0d expected 1", strobes - s0);
        end
        checks++;
        if (last_data !== EXP_B) begin
            failures++; $display("FAIL stall_resume_data: got %h expected %h", last_data, EXP_B);
        end
    endtask

    task automatic test_frame_check();
        do_reset();
        preamble();
        send_frame(32'h123456AB, 32'h89ABCDEF, 32'h00000100, 32'hFFFFFF00);
        send_half(1'b0, 24'h89ABCD, 24'hFFFFFF, 100, 20);
        checks++;
        if (frame_error !== 1'b0) begin
            failures++; $display("FAIL framechk_before: got %b expected 0", frame_error);
        end
        send_half(1'b1, 24'h123456, 24'h000001, 128, 24);
        checks++;
        if (frame_error !== FE_EXP) begin
            failures++; $display("FAIL framechk_short: got %b expected %b", frame_error, FE_EXP);
        end
        send_frame(32'h123456AB, 32'h89ABCDEF, 32'h00000100, 32'hFFFFFF00);
        checks++;
        if (frame_error !== FE_EXP) begin
            failures++; $display("FAIL framechk_sticky: got %b expected %b", frame_error, FE_EXP);
        end
    endtask

    initial begin
        @(posedge capture_clk); #1;
        test_reset();
        test_loopback();
        test_full_scale();
        test_reset_mid_right();
        test_reset_pulse();
        test_lrck_stall();
        test_frame_check();
        checks++;
        if (wide_cnt !== 0) begin
            failures++; $display("FAIL valid_width: got %0d wide strobes expected 0", wide_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
